// File: rtl/walk_gen_pkg.sv
// Shared types and helpers for the walking-one stimulus generator.
// Optional build macro: WALK_GEN_ROTATE_EN (rotate instead of shift-with-truncation).
package walk_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    WALK,
    TAIL,
    DONE
  } walk_state_e;

  // Widest bus step_pattern() can describe; callers size-cast the result.
  localparam int unsigned MAX_WIDTH = 64;

  // Pattern for walk step i on a bus of the given width.
  // Shift build: bit i is set, so step i == width falls off the bus (all zeros).
  // Rotate build: bit (i mod width) is set, so step width wraps to bit 0.
  function automatic logic [MAX_WIDTH-1:0] step_pattern(input int unsigned i,
                                                        input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    int unsigned          pos;
`ifdef WALK_GEN_ROTATE_EN
    pos = i % width;
`else
    pos = i;
`endif
    v = '0;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      v[b] = (b == pos) && (b < width);
    end
    return v;
  endfunction

endpackage

// File: rtl/walk_hold_ctr.sv
// Loadable down-counter used to time the lead-in, per-step hold and tail periods.
// zero_o is high when the count has reached 0; dec_i saturates at 0.
module walk_hold_ctr #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement.
  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/walk_pattern_gen.sv
// Walking-one stimulus source for the dff -> inv pipeline D input.
// Sequence: IDLE -> LEAD (d_out=0) -> WALK (one bit per step) -> TAIL -> DONE (done pulse) -> IDLE.
// All outputs are registered. Optional build macro: WALK_GEN_ROTATE_EN.
module walk_pattern_gen
  import walk_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LEAD_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TAIL_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic [WIDTH-1:0]           d_out,
  output logic                       d_valid,
  output logic [$clog2(WIDTH+1)-1:0] step_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned SW    = $clog2(WIDTH + 1);
  localparam int unsigned MAX_A = (LEAD_CYCLES > HOLD_CYCLES) ? LEAD_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > TAIL_CYCLES) ? MAX_A : TAIL_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_P + 1);

  // A period of N cycles is timed by loading N-1 and leaving when the counter reads zero.
  localparam logic [CW-1:0] LEAD_LOAD = CW'(LEAD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TAIL_LOAD = CW'(TAIL_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH);

  walk_state_e   state_q, state_d;
  logic [SW-1:0] step_q, step_d;

  logic          ctr_load, ctr_dec, ctr_zero;
  logic [CW-1:0] ctr_val;

  logic [WIDTH-1:0] d_out_d;
  logic             d_valid_d, busy_d, done_d;
  logic [SW-1:0]    step_idx_d;

  walk_hold_ctr #(.CW(CW)) u_hold_ctr (
    .clk       (clk),
    .rst_i     (rst),
    .load_i    (ctr_load),
    .load_val_i(ctr_val),
    .dec_i     (ctr_dec),
    .zero_o    (ctr_zero)
  );

  // Next state, step counter and period-counter control; outputs decoded from the next state.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_val  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LEAD;
          ctr_load = 1'b1;
          ctr_val  = LEAD_LOAD;
        end
      end
      LEAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ctr_zero) begin
          state_d  = WALK;
          step_d   = SW'(1);
          ctr_load = 1'b1;
          ctr_val  = HOLD_LOAD;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      WALK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ctr_zero) begin
          ctr_load = 1'b1;
          if (step_q == LAST_STEP) begin
            state_d = TAIL;
            ctr_val = TAIL_LOAD;
          end else begin
            step_d  = step_q + SW'(1);
            ctr_val = HOLD_LOAD;
          end
        end else begin
          ctr_dec = 1'b1;
        end
      end
      TAIL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ctr_zero) begin
          state_d = DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      DONE: begin
        // start and abort are both ignored here; always return to IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    d_out_d    = '0;
    d_valid_d  = 1'b0;
    step_idx_d = '0;
    busy_d     = (state_d == LEAD) || (state_d == WALK) || (state_d == TAIL);
    done_d     = (state_d == DONE);
    if (state_d == WALK) begin
      d_out_d    = WIDTH'(step_pattern(32'(step_d), WIDTH));
      d_valid_d  = 1'b1;
      step_idx_d = step_d;
    end else if (state_d == TAIL) begin
      // Tail holds the value of the final step.
      d_out_d = WIDTH'(step_pattern(WIDTH, WIDTH));
    end
  end

  // State and registered outputs; reset also clears a pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      d_out    <= '0;
      d_valid  <= 1'b0;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      d_out    <= d_out_d;
      d_valid  <= d_valid_d;
      step_idx <= step_idx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_walk_pattern_gen.sv
// Self-checking bench for walk_pattern_gen: two instances (HOLD_CYCLES=1 and 3) share stimulus;
// each is compared every cycle against a cycle-count model, plus literal spot checks.
module tb_walk_pattern_gen;

  localparam int W     = 8;
  localparam int LEAD  = 2;
  localparam int TAIL  = 4;
  localparam int HOLD0 = 1;
  localparam int HOLD1 = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [3:0] s;
    logic       b;
    logic       dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort;

  logic [7:0] d_out0, d_out1;
  logic       d_valid0, d_valid1, busy0, busy1, done0, done1;
  logic [3:0] step0, step1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: 0 = idle, otherwise the spec cycle number since start was accepted.
  int mc0 = 0;
  int mc1 = 0;

  always #5 clk = ~clk;

  walk_pattern_gen #(.WIDTH(W), .LEAD_CYCLES(LEAD), .HOLD_CYCLES(HOLD0), .TAIL_CYCLES(TAIL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .d_out(d_out0), .d_valid(d_valid0), .step_idx(step0), .busy(busy0), .done(done0)
  );

  walk_pattern_gen #(.WIDTH(W), .LEAD_CYCLES(LEAD), .HOLD_CYCLES(HOLD1), .TAIL_CYCLES(TAIL)) dut_h3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .d_out(d_out1), .d_valid(d_valid1), .step_idx(step1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
`ifdef WALK_GEN_ROTATE_EN
    return 8'd1 << (i % W);
`else
    return (i < W) ? 8'(1 << i) : 8'h00;
`endif
  endfunction

  function automatic int done_cycle(input int hold);
    return LEAD + W * hold + TAIL + 1;
  endfunction

  function automatic exp_t expect_at(input int c, input int hold);
    exp_t e;
    int   walk_end;
    e        = '0;
    walk_end = LEAD + W * hold;
    if (c >= 1 && c <= LEAD) begin
      e.b = 1'b1;
    end else if (c > LEAD && c <= walk_end) begin
      e.s = 4'((c - LEAD - 1) / hold + 1);
      e.d = pat(int'(e.s));
      e.v = 1'b1;
      e.b = 1'b1;
    end else if (c > walk_end && c <= walk_end + TAIL) begin
      e.d = pat(W);
      e.b = 1'b1;
    end else if (c == done_cycle(hold)) begin
      e.dn = 1'b1;
    end
    return e;
  endfunction

  function automatic int next_c(input int c, input int hold);
    if (rst) return 0;
    if (c == 0) return start ? 1 : 0;
    if (c == done_cycle(hold)) return 0;
    if (abort) return 0;
    return c + 1;
  endfunction

  always @(posedge clk) begin
    mc0 = next_c(mc0, HOLD0);
    mc1 = next_c(mc1, HOLD1);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_h1", 32'({d_out0, d_valid0, step0, busy0, done0}), 32'(expect_at(mc0, HOLD0)));
      check("model_h3", 32'({d_out1, d_valid1, step1, busy1, done1}), 32'(expect_at(mc1, HOLD1)));
`ifdef WALK_GEN_ROTATE_EN
      if (d_valid0) check("onehot_h1", 32'($countones(d_out0)), 32'd1);
      if (d_valid1) check("onehot_h3", 32'($countones(d_out1)), 32'd1);
`endif
    end
  end

  // Start a run at the next edge and walk spec cycles 1..34 with literal spot checks.
  task automatic run_directed(input bit extra_starts);
    int dones0, dones1;
    logic [7:0] last_val;
`ifdef WALK_GEN_ROTATE_EN
    last_val = 8'h01;
`else
    last_val = 8'h00;
`endif
    dones0 = 0;
    dones1 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (done0) dones0++;
      if (done1) dones1++;
      if (c == 2) begin
        check("lead_d_out", 32'(d_out0), 32'h00);
        check("lead_busy", 32'(busy0), 32'd1);
      end
      if (c == 3) begin
        check("step1_d_out", 32'(d_out0), 32'h02);
        check("step1_idx", 32'(step0), 32'd1);
      end
      if (c == 5) check("h3_step1_d_out", 32'(d_out1), 32'h02);
      if (c == 6) check("h3_step2_d_out", 32'(d_out1), 32'h04);
      if (c == 9) check("step7_d_out", 32'(d_out0), 32'h80);
      if (c == 10) begin
        check("step8_d_out", 32'(d_out0), 32'(last_val));
        check("step8_idx", 32'(step0), 32'd8);
      end
      if (c == 11) check("tail_valid", 32'(d_valid0), 32'd0);
      if (c == 14) check("tail_no_done", 32'(done0), 32'd0);
      if (c == 15) begin
        check("done_c15", 32'(done0), 32'd1);
        check("done_busy", 32'(busy0), 32'd0);
      end
      if (c == 31) check("h3_done_c31", 32'(done1), 32'd1);
      start = extra_starts && (c == 4 || c == 15);
      @(negedge clk);
    end
    start = 1'b0;
    check("one_done_h1", 32'(dones0), 32'd1);
    check("one_done_h3", 32'(dones1), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_d_out", 32'(d_out0), 32'h00);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(busy0), 32'd0);

    // Plain run, then a run with starts that must be ignored.
    run_directed(1'b0);
    run_directed(1'b1);

    // Abort mid-walk, then confirm a clean restart.
    begin
      int dones;
      dones = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (done0) dones++;
        if (c == 5) begin
          check("pre_abort_d_out", 32'(d_out0), 32'h08);
          abort = 1'b1;
        end
        if (c == 6) begin
          check("abort_d_out", 32'(d_out0), 32'h00);
          check("abort_busy", 32'(busy0), 32'd0);
          abort = 1'b0;
        end
        @(negedge clk);
      end
      check("abort_no_done", 32'(dones), 32'd0);
    end
    run_directed(1'b0);

    // Random start/abort/reset traffic checked by the model.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (45) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
